// File: rtl/proc_clk_pkg.sv
// Shared encodings for the processor clock controller.
// Mode/state values and output widths.
package proc_clk_pkg;

  localparam int MODE_W = 2;
  localparam int TICK_W = 16;

  typedef enum logic [MODE_W-1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-cycle debounce counter.
// o_level only moves after a full interval of disagreement.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level
);

  logic        r_s1;
  logic        r_s2;
  logic        r_level;
  logic [19:0] r_cnt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // any agreeing cycle restarts the interval
      if (r_s2 != r_level) begin
        if (r_cnt >= DEBOUNCE_CYCLES - 20'd1) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/proc_clock_ctrl.sv
// Processor clock-enable controller: HALT / RUN / STEP
// driven by debounced run switch, step button and slow_clk ticks.
module proc_clock_ctrl
  import proc_clk_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              slow_clk,
  input  logic              step_btn,
  input  logic              run_sw,
  input  logic              halt_req,
  output logic              proc_en,
  output logic [MODE_W-1:0] mode,
  output logic [TICK_W-1:0] tick_count
);

  logic              r_slow_s1;
  logic              r_slow_s2;
  logic              r_slow_prev;
  logic              r_step_prev;
  logic              r_run_prev;
  logic              r_proc_en;
  logic [TICK_W-1:0] r_tick;
  state_t            r_state;
  state_t            w_next;
  logic              w_pulse;
  logic              w_slow_tick;
  logic              w_step_db;
  logic              w_run_db;
  logic              w_step_req;
  logic              w_run_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .i_raw   (step_btn),
    .o_level (w_step_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .i_raw   (run_sw),
    .o_level (w_run_db)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_slow_s1   <= 1'b0;
      r_slow_s2   <= 1'b0;
      r_slow_prev <= 1'b0;
      r_step_prev <= 1'b0;
      r_run_prev  <= 1'b0;
    end else begin
      r_slow_s1   <= slow_clk;
      r_slow_s2   <= r_slow_s1;
      r_slow_prev <= r_slow_s2;
      r_step_prev <= w_step_db;
      r_run_prev  <= w_run_db;
    end
  end

  assign w_slow_tick = r_slow_s2 & ~r_slow_prev;
  assign w_step_req  = w_step_db & ~r_step_prev;
  assign w_run_rise  = w_run_db & ~r_run_prev;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HALT: begin
        if (w_run_rise) begin
          w_next = ST_RUN;
        end else if (w_step_req) begin
          w_next = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req || !w_run_db) begin
          w_next = ST_HALT;
        end
      end
      ST_STEP: begin
        if (halt_req || w_slow_tick) begin
          w_next = ST_HALT;
        end
      end
      default: w_next = ST_HALT;
    endcase
  end

  always_comb begin
    w_pulse = 1'b0;
    case (r_state)
      ST_RUN:  w_pulse = w_slow_tick & ~halt_req & w_run_db;
      ST_STEP: w_pulse = w_slow_tick & ~halt_req;
      default: w_pulse = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_proc_en <= 1'b0;
      r_tick    <= '0;
    end else begin
      r_proc_en <= w_pulse;
      if (r_proc_en) begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

  assign proc_en    = r_proc_en;
  assign mode       = r_state;
  assign tick_count = r_tick;

endmodule

// File: tb/tb_proc_clock_ctrl.sv
// Bench for proc_clock_ctrl with a short debounce interval.
// Mode vectors from a table; proc_en pulses against a scoreboard.
module tb_proc_clock_ctrl;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        slow_clk = 1'b0;
  logic        step_btn = 1'b0;
  logic        run_sw   = 1'b0;
  logic        halt_req = 1'b0;
  logic        proc_en;
  logic [1:0]  mode;
  logic [15:0] tick_count;

  always #5 clock_in = ~clock_in;

  proc_clock_ctrl #(
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .slow_clk  (slow_clk),
    .step_btn  (step_btn),
    .run_sw    (run_sw),
    .halt_req  (halt_req),
    .proc_en   (proc_en),
    .mode      (mode),
    .tick_count(tick_count)
  );

  typedef struct {
    int          cyc;
    logic [15:0] tc;
  } exp_t;

  typedef struct {
    bit         run;
    bit         step;
    bit         halt;
    int         hold;
    logic [1:0] mode;
    string      nm;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc_n    = 0;
  logic [15:0] exp_ticks = '0;
  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[$];

  always @(posedge clock_in) cyc_n <= cyc_n + 1;

  // every proc_en cycle must match the next scoreboard entry
  always @(negedge clock_in) begin
    if (proc_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d tick=%0d",
                 cyc_n, tick_count);
      end else begin
        mon_e = sb.pop_front();
        if (cyc_n != mon_e.cyc || tick_count !== mon_e.tc) begin
          failures++;
          $display("FAIL pulse got cyc=%0d tick=%0d exp cyc=%0d tick=%0d",
                   cyc_n, tick_count, mon_e.cyc, mon_e.tc);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic slow_rise(int half, bit pulse);
    slow_clk = 1'b1;
    if (pulse) begin
      sb.push_back('{cyc_n + 3, exp_ticks});
      exp_ticks++;
    end
    tick(half);
    slow_clk = 1'b0;
    tick(half);
  endtask

  initial begin
    vt.push_back('{0, 1, 0, 2, 2'b00, "bounce1_hi"});
    vt.push_back('{0, 0, 0, 2, 2'b00, "bounce1_lo"});
    vt.push_back('{0, 1, 0, 2, 2'b00, "bounce2_hi"});
    vt.push_back('{0, 0, 0, 2, 2'b00, "bounce2_lo"});
    vt.push_back('{0, 1, 0, 2, 2'b00, "bounce3_hi"});
    vt.push_back('{0, 0, 0, 2, 2'b00, "bounce3_lo"});
    vt.push_back('{0, 1, 0, 6, 2'b00, "step_latency"});
    vt.push_back('{0, 1, 0, 1, 2'b10, "step_enter"});
    vt.push_back('{0, 1, 1, 1, 2'b00, "step_halt"});
    vt.push_back('{0, 1, 0, 4, 2'b00, "step_held"});
    vt.push_back('{0, 0, 0, 8, 2'b00, "step_release"});
    vt.push_back('{1, 1, 0, 6, 2'b00, "prio_latency"});
    vt.push_back('{1, 1, 0, 1, 2'b01, "prio_run"});
    vt.push_back('{1, 0, 0, 8, 2'b01, "run_hold"});

    tick(2);
    chk("reset_proc_en", 32'(proc_en), 32'd0);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_ticks", 32'(tick_count), 32'd0);
    reset_n = 1'b1;
    tick(3);

    for (int i = 0; i < vt.size(); i++) begin
      run_sw   = vt[i].run;
      step_btn = vt[i].step;
      halt_req = vt[i].halt;
      tick(vt[i].hold);
      chk(vt[i].nm, 32'(mode), 32'(vt[i].mode));
    end
    halt_req = 1'b0;

    // three RUN pulses, slow_clk period 8
    for (int i = 0; i < 3; i++) slow_rise(4, 1'b1);
    tick(2);
    chk("run_ticks3", 32'(tick_count), 32'd3);

    // halt_req coincident with slow_tick
    slow_clk = 1'b1;
    tick(2);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("halt_coincident", 32'(mode), 32'd0);
    tick(1);
    slow_clk = 1'b0;
    tick(4);
    slow_rise(4, 1'b0);
    slow_rise(4, 1'b0);
    chk("halt_stays", 32'(mode), 32'd0);
    chk("halt_ticks", 32'(tick_count), 32'd3);
    run_sw = 1'b0;
    tick(8);
    chk("halt_run_low", 32'(mode), 32'd0);
    run_sw = 1'b1;
    tick(6);
    chk("rerun_latency", 32'(mode), 32'd0);
    tick(1);
    chk("rerun", 32'(mode), 32'd1);

    // run_sw dropped while running
    slow_rise(4, 1'b1);
    run_sw = 1'b0;
    tick(6);
    chk("run_drop_latency", 32'(mode), 32'd1);
    tick(1);
    chk("run_drop", 32'(mode), 32'd0);
    run_sw = 1'b1;
    tick(7);
    chk("run_again", 32'(mode), 32'd1);

    // single step from HALT
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    chk("halt_for_step", 32'(mode), 32'd0);
    step_btn = 1'b1;
    tick(7);
    chk("step_mode", 32'(mode), 32'd2);
    tick(3);
    chk("step_wait", 32'(mode), 32'd2);
    slow_clk = 1'b1;
    sb.push_back('{cyc_n + 3, exp_ticks});
    exp_ticks++;
    tick(3);
    chk("step_done", 32'(mode), 32'd0);
    tick(1);
    slow_clk = 1'b0;
    tick(4);
    slow_rise(4, 1'b0);
    chk("step_once", 32'(mode), 32'd0);
    chk("step_ticks", 32'(tick_count), 32'(exp_ticks));
    step_btn = 1'b0;
    tick(8);

    // reset in the middle of RUN with a tick in flight
    run_sw = 1'b0;
    tick(8);
    run_sw = 1'b1;
    tick(7);
    chk("run_before_reset", 32'(mode), 32'd1);
    slow_rise(4, 1'b1);
    slow_clk = 1'b1;
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_proc_en", 32'(proc_en), 32'd0);
    chk("midrun_reset_mode", 32'(mode), 32'd0);
    chk("midrun_reset_ticks", 32'(tick_count), 32'd0);
    chk("sb_before_reset", 32'(sb.size()), 32'd0);
    exp_ticks = '0;
    slow_clk  = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(6);
    chk("post_reset_latency", 32'(mode), 32'd0);
    tick(1);
    chk("post_reset_run", 32'(mode), 32'd1);

    // full wrap of tick_count, slow_clk period 4
    for (int i = 0; i < 65536; i++) slow_rise(2, 1'b1);
    tick(4);
    chk("wrap_ticks", 32'(tick_count), 32'd0);
    chk("wrap_mode", 32'(mode), 32'd1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
